// File: rtl/sr_lsu.sv
// -----------------------------------------------------------------------------
// sr_lsu: load/store unit between the memory-stage decode and the byte
// addressable data RAM (sr_ram).
//
// One request is accepted at a time over a valid/ready handshake. The RISC-V
// funct3 code is translated into the RAM's op_word/op_half/op_byte/sign
// controls. Illegal, misaligned and out-of-range requests are rejected without
// touching memory. A registered response returns the load data, the echoed
// destination tag and a fault code.
//
// Ports:
//   clk, rst                  clock (rising edge), asynchronous active-high reset
//   req_valid / req_ready     request handshake
//   req_we                    1 = store, 0 = load
//   req_funct3                RISC-V width/sign code
//   req_addr                  byte address
//   req_wdata                 store data (low bytes used)
//   req_rd                    destination register tag
//   resp_valid / resp_ready   response handshake
//   resp_rdata                extended load result (0 for stores and faults)
//   resp_rd                   echoed req_rd
//   resp_fault, resp_cause    0 none, 1 misaligned, 2 out of range, 3 illegal
//   mem_addr, mem_wdata       RAM address / write data (hold last values)
//   mem_we, mem_sign          RAM write enable / sign-extend select
//   mem_op_word/half/byte     RAM width select, one-hot in ACCESS, else zero
//   mem_rdata                 RAM combinational read data
// -----------------------------------------------------------------------------
module sr_lsu #(
    parameter int DEPTH = 256
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [2:0]  req_funct3,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [4:0]  req_rd,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic [4:0]  resp_rd,
    output logic        resp_fault,
    output logic [1:0]  resp_cause,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_we,
    output logic        mem_sign,
    output logic        mem_op_word,
    output logic        mem_op_half,
    output logic        mem_op_byte,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t      r_state;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;
    logic [4:0]  r_rd;
    logic        r_fault;
    logic [1:0]  r_cause;
    logic        r_req_ready;
    logic        r_resp_valid;

    logic        w_illegal;
    logic        w_misaligned;
    logic        w_range;
    logic [2:0]  w_size;
    logic [32:0] w_end;
    logic [1:0]  w_cause;
    logic        w_access;

    // Request classification, evaluated on the live request while IDLE.
    always_comb begin
        w_illegal    = 1'b0;
        w_misaligned = 1'b0;
        w_size       = 3'd4;
        w_cause      = 2'd0;

        if (req_we)
            w_illegal = (req_funct3 > 3'b010);
        else
            w_illegal = (req_funct3 == 3'b011) || (req_funct3[2:1] == 2'b11);

        case (req_funct3[1:0])
            2'b00:   w_size = 3'd1;
            2'b01:   w_size = 3'd2;
            default: w_size = 3'd4;
        endcase

        w_misaligned = ((req_funct3[1:0] == 2'b01) && req_addr[0]) ||
                       ((req_funct3[1:0] == 2'b10) && (req_addr[1:0] != 2'b00));

        // 33-bit end address so that an address near 0xFFFFFFFF cannot wrap
        // back into range.
        w_end   = {1'b0, req_addr} + {30'd0, w_size};
        w_range = (w_end > 33'(DEPTH));

        if (w_illegal)
            w_cause = 2'd3;
        else if (w_misaligned)
            w_cause = 2'd1;
        else if (w_range)
            w_cause = 2'd2;
        else
            w_cause = 2'd0;
    end

    // Control FSM and response registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_we         <= 1'b0;
            r_funct3     <= 3'd0;
            r_addr       <= 32'd0;
            r_wdata      <= 32'd0;
            r_rdata      <= 32'd0;
            r_rd         <= 5'd0;
            r_fault      <= 1'b0;
            r_cause      <= 2'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (req_valid) begin
                        r_we        <= req_we;
                        r_funct3    <= req_funct3;
                        r_addr      <= req_addr;
                        r_wdata     <= req_wdata;
                        r_rd        <= req_rd;
                        r_rdata     <= 32'd0;
                        r_fault     <= (w_cause != 2'd0);
                        r_cause     <= w_cause;
                        r_req_ready <= 1'b0;
                        if (w_cause != 2'd0) begin
                            // Faults skip the RAM entirely.
                            r_state      <= S_RESP;
                            r_resp_valid <= 1'b1;
                        end else begin
                            r_state <= S_ACCESS;
                        end
                    end
                end
                S_ACCESS: begin
                    if (!r_we)
                        r_rdata <= mem_rdata;
                    r_state      <= S_RESP;
                    r_resp_valid <= 1'b1;
                end
                S_RESP: begin
                    if (resp_ready) begin
                        r_state      <= S_IDLE;
                        r_resp_valid <= 1'b0;
                        r_req_ready  <= 1'b1;
                    end
                end
                default: begin
                    r_state      <= S_IDLE;
                    r_resp_valid <= 1'b0;
                    r_req_ready  <= 1'b1;
                end
            endcase
        end
    end

    // RAM strobes are gated by the ACCESS state so an asynchronous reset
    // removes them immediately and no partial write can complete.
    assign w_access    = (r_state == S_ACCESS);
    assign mem_we      = w_access & r_we;
    assign mem_op_byte = w_access & (r_funct3[1:0] == 2'b00);
    assign mem_op_half = w_access & (r_funct3[1:0] == 2'b01);
    assign mem_op_word = w_access & (r_funct3[1:0] == 2'b10);
    assign mem_sign    = w_access & ~r_we & ~r_funct3[2] & (r_funct3[1:0] != 2'b10);
    assign mem_addr    = r_addr;
    assign mem_wdata   = r_wdata;

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_rdata;
    assign resp_rd    = r_rd;
    assign resp_fault = r_fault;
    assign resp_cause = r_cause;

endmodule

// File: tb/tb_sr_lsu.sv
module tb_sr_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_fault;
    logic [1:0]  resp_cause;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_we;
    logic        mem_sign;
    logic        mem_op_word;
    logic        mem_op_half;
    logic        mem_op_byte;
    logic [31:0] mem_rdata;

    int nvec;
    int nerr;

    sr_lsu #(.DEPTH(256)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_funct3 (req_funct3),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .req_rd     (req_rd),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_rd    (resp_rd),
        .resp_fault (resp_fault),
        .resp_cause (resp_cause),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .mem_we     (mem_we),
        .mem_sign   (mem_sign),
        .mem_op_word(mem_op_word),
        .mem_op_half(mem_op_half),
        .mem_op_byte(mem_op_byte),
        .mem_rdata  (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural model of the 256-byte data RAM.
    logic [7:0]  ram [0:255];
    logic        clr;
    logic [7:0]  ra;
    logic [15:0] rh;
    logic [7:0]  rb;

    always_comb begin
        ra        = mem_addr[7:0];
        rh        = {ram[ra + 8'd1], ram[ra]};
        rb        = ram[ra];
        mem_rdata = 32'd0;
        if (mem_op_word)
            mem_rdata = {ram[ra + 8'd3], ram[ra + 8'd2], ram[ra + 8'd1], ram[ra]};
        else if (mem_op_half)
            mem_rdata = mem_sign ? {{16{rh[15]}}, rh} : {16'd0, rh};
        else if (mem_op_byte)
            mem_rdata = mem_sign ? {{24{rb[7]}}, rb} : {24'd0, rb};
    end

    always @(posedge clk) begin
        if (clr) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'h00;
        end else if (mem_we) begin
            ram[ra] <= mem_wdata[7:0];
            if (mem_op_half || mem_op_word) ram[ra + 8'd1] <= mem_wdata[15:8];
            if (mem_op_word) begin
                ram[ra + 8'd2] <= mem_wdata[23:16];
                ram[ra + 8'd3] <= mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    // One complete transaction with resp_ready held high. lat counts cycles
    // from the acceptance edge (1 = visible right after that edge).
    task automatic xact(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, input logic [4:0] rd,
                        output logic [31:0] rdata, output logic flt, output logic [1:0] cs,
                        output logic [4:0] rrd, output int lat, output int nwe,
                        output int nacc, output logic [31:0] maddr, output logic [31:0] mwd);
        for (int i = 0; i < 10 && !req_ready; i++) begin
            @(posedge clk); #1;
        end
        resp_ready = 1'b1;
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = a;
        req_wdata  = wd;
        req_rd     = rd;
        @(posedge clk); #1;
        req_valid = 1'b0;
        lat = 0; nwe = 0; nacc = 0;
        rdata = 32'hx; flt = 1'bx; cs = 2'bx; rrd = 5'bx;
        maddr = 32'hx; mwd = 32'hx;
        for (int i = 1; i <= 8; i++) begin
            if (mem_we) nwe++;
            if (mem_op_word || mem_op_half || mem_op_byte) begin
                nacc++;
                maddr = mem_addr;
                mwd   = mem_wdata;
            end
            if (resp_valid) begin
                lat   = i;
                rdata = resp_rdata;
                flt   = resp_fault;
                cs    = resp_cause;
                rrd   = resp_rd;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    logic [31:0] rdata, maddr, mwd;
    logic        flt;
    logic [1:0]  cs;
    logic [4:0]  rrd;
    int          lat, nwe, nacc;

    initial begin
        nvec = 0; nerr = 0;
        rst = 1'b1; clr = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0; resp_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_mem_ops", {mem_op_word, mem_op_half, mem_op_byte, mem_sign}, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_mem_addr", mem_addr, 0);
        rst = 1'b0; clr = 1'b0;
        @(posedge clk); #1;

        // SW then LW
        xact(1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 5'd1, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("sw_fault", flt, 0);
        chk("sw_lat", lat, 2);
        chk("sw_we_cycles", nwe, 1);
        chk("sw_mem_addr", maddr, 32'h10);
        chk("sw_mem_wdata", mwd, 32'hDEADBEEF);
        chk("sw_resp_rdata", rdata, 0);
        chk("sw_ram", {ram[8'h13], ram[8'h12], ram[8'h11], ram[8'h10]}, 32'hDEADBEEF);
        xact(1'b0, 3'b010, 32'h10, 32'h0, 5'd2, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lw_rdata", rdata, 32'hDEADBEEF);
        chk("lw_fault", flt, 0);
        chk("lw_rd", rrd, 2);
        chk("lw_we_cycles", nwe, 0);
        chk("lw_lat", lat, 2);

        // Extension tests
        xact(1'b1, 3'b000, 32'h20, 32'h00000080, 5'd0, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("sb20_fault", flt, 0);
        xact(1'b1, 3'b000, 32'h22, 32'hFFFFFFFF, 5'd0, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        xact(1'b1, 3'b000, 32'h23, 32'h0000007F, 5'd0, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("sb_ram", {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]}, 32'h7FFF0080);
        xact(1'b0, 3'b000, 32'h20, 32'h0, 5'd3, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lb_rdata", rdata, 32'hFFFFFF80);
        xact(1'b0, 3'b100, 32'h20, 32'h0, 5'd3, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lbu_rdata", rdata, 32'h00000080);
        xact(1'b0, 3'b001, 32'h22, 32'h0, 5'd4, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lh_rdata", rdata, 32'h00007FFF);
        xact(1'b0, 3'b001, 32'h20, 32'h0, 5'd4, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lh20_rdata", rdata, 32'h00000080);
        xact(1'b0, 3'b101, 32'h22, 32'h0, 5'd4, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lhu_rdata", rdata, 32'h00007FFF);

        // Misaligned
        xact(1'b0, 3'b010, 32'h13, 32'h0, 5'd5, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lw13_fault", flt, 1);
        chk("lw13_cause", cs, 1);
        chk("lw13_access", nacc, 0);
        chk("lw13_lat", lat, 1);
        chk("lw13_rdata", rdata, 0);
        xact(1'b1, 3'b001, 32'h21, 32'h00001234, 5'd5, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("sh21_cause", cs, 1);
        chk("sh21_we_cycles", nwe, 0);
        chk("sh21_ram", {ram[8'h23], ram[8'h22], ram[8'h21], ram[8'h20]}, 32'h7FFF0080);

        // Range
        xact(1'b1, 3'b010, 32'hFC, 32'h0BADF00D, 5'd6, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("swfc_fault", flt, 0);
        xact(1'b0, 3'b010, 32'hFC, 32'h0, 5'd6, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lwfc_fault", flt, 0);
        chk("lwfc_rdata", rdata, 32'h0BADF00D);
        xact(1'b0, 3'b001, 32'hFE, 32'h0, 5'd6, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lhfe_fault", flt, 0);
        chk("lhfe_rdata", rdata, 32'h00000BAD);
        xact(1'b0, 3'b010, 32'h100, 32'h0, 5'd6, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lw100_cause", cs, 2);
        chk("lw100_fault", flt, 1);
        xact(1'b0, 3'b000, 32'hFFFFFFFF, 32'h0, 5'd6, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lbffff_cause", cs, 2);
        xact(1'b0, 3'b010, 32'hFD, 32'h0, 5'd6, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("lwfd_cause", cs, 1);

        // Illegal funct3
        xact(1'b0, 3'b011, 32'h13, 32'h0, 5'd8, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("ld011_cause", cs, 3);
        chk("ld011_rd", rrd, 8);
        xact(1'b0, 3'b110, 32'h10, 32'h0, 5'd8, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("ld110_cause", cs, 3);
        xact(1'b1, 3'b100, 32'h10, 32'h12345678, 5'd8, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("st100_cause", cs, 3);
        chk("st100_we_cycles", nwe, 0);
        chk("st100_ram", {ram[8'h13], ram[8'h12], ram[8'h11], ram[8'h10]}, 32'hDEADBEEF);

        // Backpressure with tag 7
        resp_ready = 1'b0;
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h10; req_wdata = 32'h0; req_rd = 5'd7;
        @(posedge clk); #1;
        req_valid = 1'b0;
        for (int i = 0; i < 8 && !resp_valid; i++) begin
            @(posedge clk); #1;
        end
        chk("bp_valid", resp_valid, 1);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", resp_valid, 1);
            chk("bp_hold_rdata", resp_rdata, 32'hDEADBEEF);
            chk("bp_hold_rd", resp_rd, 7);
            chk("bp_hold_fault", {resp_fault, resp_cause}, 0);
            chk("bp_req_ready", req_ready, 0);
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_retire_valid", resp_valid, 0);
        chk("bp_retire_ready", req_ready, 1);

        // Reset during ACCESS of a byte store
        xact(1'b1, 3'b000, 32'h30, 32'h000000A5, 5'd9, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("sb30_ram", ram[8'h30], 32'hA5);
        req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'b000;
        req_addr = 32'h30; req_wdata = 32'h00000055; req_rd = 5'd10;
        @(posedge clk); #1;
        req_valid = 1'b0;
        chk("rst_mid_we_before", mem_we, 1);
        rst = 1'b1;
        #1;
        chk("rst_mid_we", mem_we, 0);
        chk("rst_mid_op_byte", mem_op_byte, 0);
        chk("rst_mid_req_ready", req_ready, 1);
        chk("rst_mid_resp_valid", resp_valid, 0);
        chk("rst_mid_mem_wdata", mem_wdata, 0);
        chk("rst_mid_resp_rd", resp_rd, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            chk("rst_no_resp", resp_valid, 0);
        end
        chk("rst_ram30", ram[8'h30], 32'hA5);
        chk("rst_req_ready_after", req_ready, 1);
        xact(1'b0, 3'b000, 32'h30, 32'h0, 5'd11, rdata, flt, cs, rrd, lat, nwe, nacc, maddr, mwd);
        chk("post_rst_lb", rdata, 32'hFFFFFFA5);
        chk("post_rst_rd", rrd, 11);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
